// File: rtl/fc_dense_layer.sv
// Dense layer: one neuron at a time through a single MAC, followed by shift, ReLU and saturation.
// Latency: OUT_NEURONS*(IN_SIZE+3) cycles of neuron work plus one DONE cycle after start is sampled.
// Backpressure: none; SRAMs answer in one cycle, and start is ignored unless the FSM is idle.
module fc_dense_layer #(
    parameter int DATA_WIDTH  = 8,
    parameter int IN_SIZE     = 9,
    parameter int OUT_NEURONS = 4,
    parameter int ACC_WIDTH   = 24,
    parameter int SHIFT       = 0
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   start,
    output logic                                   busy,
    output logic                                   done,
    output logic [$clog2(IN_SIZE)-1:0]             act_addr,
    output logic                                   act_rd_en,
    input  logic [DATA_WIDTH-1:0]                  act_data,
    output logic [$clog2(IN_SIZE*OUT_NEURONS)-1:0] wt_addr,
    output logic                                   wt_rd_en,
    input  logic [DATA_WIDTH-1:0]                  wt_data,
    output logic [$clog2(OUT_NEURONS)-1:0]         bias_addr,
    output logic                                   bias_rd_en,
    input  logic [ACC_WIDTH-1:0]                   bias_data,
    output logic [$clog2(OUT_NEURONS)-1:0]         out_addr,
    output logic [DATA_WIDTH-1:0]                  out_data,
    output logic                                   out_wr_en
);

    localparam int AW = $clog2(IN_SIZE);
    localparam int WW = $clog2(IN_SIZE*OUT_NEURONS);
    localparam int NW = $clog2(OUT_NEURONS);
    localparam int PW = 2*DATA_WIDTH + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_BIAS,
        S_MAC,
        S_DRAIN,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                       state_q, state_d;
    logic [NW-1:0]                n_q, n_d;
    logic [AW-1:0]                i_q, i_d;
    // Weights are laid out neuron-major, so the weight address simply runs
    // 0..IN_SIZE*OUT_NEURONS-1 across the whole layer.
    logic [WW-1:0]                wt_ptr_q, wt_ptr_d;
    logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;

    // All outputs are registered; their _d values are decoded from the next
    // state so each strobe lines up with the state it belongs to.
    logic                         busy_q, busy_d;
    logic                         done_q, done_d;
    logic [AW-1:0]                act_addr_q, act_addr_d;
    logic                         act_rd_en_q, act_rd_en_d;
    logic [WW-1:0]                wt_addr_q, wt_addr_d;
    logic                         wt_rd_en_q, wt_rd_en_d;
    logic [NW-1:0]                bias_addr_q, bias_addr_d;
    logic                         bias_rd_en_q, bias_rd_en_d;
    logic [NW-1:0]                out_addr_q, out_addr_d;
    logic [DATA_WIDTH-1:0]        out_data_q, out_data_d;
    logic                         out_wr_en_q, out_wr_en_d;

    // Activation is unsigned: prepend a zero so the signed multiply treats it as positive.
    logic signed [DATA_WIDTH:0]   act_s;
    logic signed [DATA_WIDTH-1:0] wt_s;
    logic signed [PW-1:0]         prod;
    logic signed [ACC_WIDTH-1:0]  prod_ext;

    assign act_s    = {1'b0, act_data};
    assign wt_s     = wt_data;
    assign prod     = PW'(act_s) * PW'(wt_s);
    assign prod_ext = ACC_WIDTH'(prod);

    // Arithmetic shift, then clamp to [0, 2^DATA_WIDTH-1].
    function automatic logic [DATA_WIDTH-1:0] act_fn(input logic signed [ACC_WIDTH-1:0] a);
        logic signed [ACC_WIDTH-1:0] s;
        s = a >>> SHIFT;
        if (s[ACC_WIDTH-1]) begin
            return '0;
        end else if (|s[ACC_WIDTH-2:DATA_WIDTH]) begin
            return '1;
        end else begin
            return s[DATA_WIDTH-1:0];
        end
    endfunction

    // Accumulator: load bias on the first MAC cycle, then add the product of
    // the previous issue on every later MAC cycle and in DRAIN.
    always_comb begin
        acc_d = acc_q;
        if (state_q == S_MAC && i_q == '0) begin
            acc_d = $signed(bias_data);
        end else if (state_q == S_MAC || state_q == S_DRAIN) begin
            acc_d = acc_q + prod_ext;
        end
    end

    // Next-state, counters and registered-output decode.
    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        i_d      = i_q;
        wt_ptr_d = wt_ptr_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_BIAS;
                    n_d      = '0;
                    wt_ptr_d = '0;
                end
            end
            S_BIAS: begin
                state_d = S_MAC;
                i_d     = '0;
            end
            S_MAC: begin
                if (i_q == AW'(IN_SIZE-1)) begin
                    state_d = S_DRAIN;
                end else begin
                    i_d = i_q + 1'b1;
                end
            end
            S_DRAIN: begin
                state_d = S_WRITE;
            end
            S_WRITE: begin
                if (n_q == NW'(OUT_NEURONS-1)) begin
                    state_d = S_DONE;
                end else begin
                    n_d     = n_q + 1'b1;
                    state_d = S_BIAS;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Weight pointer advances once per issued MAC read.
        if (state_d == S_MAC) begin
            wt_ptr_d = wt_ptr_q + 1'b1;
        end

        busy_d       = (state_d != S_IDLE);
        done_d       = (state_d == S_DONE);
        bias_rd_en_d = (state_d == S_BIAS);
        act_rd_en_d  = (state_d == S_MAC);
        wt_rd_en_d   = (state_d == S_MAC);
        out_wr_en_d  = (state_d == S_WRITE);

        // Addresses and result data hold their last value when not in use.
        bias_addr_d  = bias_rd_en_d ? n_d      : bias_addr_q;
        act_addr_d   = act_rd_en_d  ? i_d      : act_addr_q;
        wt_addr_d    = wt_rd_en_d   ? wt_ptr_q : wt_addr_q;
        out_addr_d   = out_wr_en_d  ? n_d      : out_addr_q;
        out_data_d   = out_wr_en_d  ? act_fn(acc_d) : out_data_q;
    end

    // State, counters, accumulator and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            n_q          <= '0;
            i_q          <= '0;
            wt_ptr_q     <= '0;
            acc_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            act_addr_q   <= '0;
            act_rd_en_q  <= 1'b0;
            wt_addr_q    <= '0;
            wt_rd_en_q   <= 1'b0;
            bias_addr_q  <= '0;
            bias_rd_en_q <= 1'b0;
            out_addr_q   <= '0;
            out_data_q   <= '0;
            out_wr_en_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            n_q          <= n_d;
            i_q          <= i_d;
            wt_ptr_q     <= wt_ptr_d;
            acc_q        <= acc_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            act_addr_q   <= act_addr_d;
            act_rd_en_q  <= act_rd_en_d;
            wt_addr_q    <= wt_addr_d;
            wt_rd_en_q   <= wt_rd_en_d;
            bias_addr_q  <= bias_addr_d;
            bias_rd_en_q <= bias_rd_en_d;
            out_addr_q   <= out_addr_d;
            out_data_q   <= out_data_d;
            out_wr_en_q  <= out_wr_en_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign act_addr   = act_addr_q;
    assign act_rd_en  = act_rd_en_q;
    assign wt_addr    = wt_addr_q;
    assign wt_rd_en   = wt_rd_en_q;
    assign bias_addr  = bias_addr_q;
    assign bias_rd_en = bias_rd_en_q;
    assign out_addr   = out_addr_q;
    assign out_data   = out_data_q;
    assign out_wr_en  = out_wr_en_q;

endmodule
